booth_mul_seq: RTL
==================

# booth_mul_seq

Parametrised, sequential radix-2 Booth multiplier with a start/done handshake and a run-time signed/unsigned mode. It is the clocked successor to the combinational 4-bit Booth multiplier: one Booth step per clock, any operand width, and correct unsigned results. It sits in the datapath as a multi-cycle arithmetic unit driven by a controller that issues `start` and waits for `done`.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be at least 2. Product is 2*WIDTH bits.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE or DONE.
- `signed_mode`, input, 1: 1 means operands are two's complement; 0 means unsigned. Sampled with `start`.
- `mcand`, input, WIDTH: multiplicand (M). Sampled with `start`.
- `mplier`, input, WIDTH: multiplier (Q). Sampled with `start`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high for exactly one cycle when `product` is updated.
- `product`, output, 2*WIDTH: result register. Holds its value until the next completion.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE with `start`=1 goes to RUN.
  - RUN goes to DONE when the iteration count reaches WIDTH+1.
  - DONE with `start`=1 goes to RUN (back-to-back operation).
  - DONE with `start`=0 goes to IDLE.
- **Load on accepted start:**
  - Extend both operands to WIDTH+1 bits: sign-extend if `signed_mode`=1, zero-extend otherwise.
  - Clear the accumulator (2*WIDTH+2 bits).
  - Clear the Booth carry bit C.
  - Clear the iteration counter.
- **Each RUN cycle performs one Booth step on {Q[0], C}:**
  - 10: subtract shifted M.
  - 01: add shifted M.
  - 00 or 11: no operation.
  - Then shift {Q, C} right by one, arithmetically, and shift M left by one.
  - All arithmetic is modulo 2^(2*WIDTH+2).
- **Result:** after WIDTH+1 steps, `product` = accumulator[2*WIDTH-1:0].
  - Signed mode: `product` is the exact two's-complement product.
  - Unsigned mode: `product` is the exact unsigned product.
  - The value is exact in both modes, including the most-negative × most-negative case.
- **Start while busy:** `start` in RUN is ignored. The operands in flight are unaffected.
- **Input changes:** operand and mode inputs may change freely after the accepting edge.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `product`=0, counter=0.
- **Reset mid-operation:** `rst` in RUN or DONE returns to IDLE at that edge.
  - `product` clears to 0.
  - No `done` is produced for the aborted operation.
- **Latency:** `start` accepted at edge k.
  - `busy`=1 after edges k through k+WIDTH.
  - `product` is written and `done`=1 after edge k+WIDTH+1.
  - `done` drops after edge k+WIDTH+2 unless a new operation completes then.
  - Fixed latency is WIDTH+1 clocks from accepting edge to `done`, independent of data.
- **Throughput:** with `start` held high, one result every WIDTH+2 clocks. `done` and `busy` are never high in the same cycle.
- **Simultaneous rst and start:** `rst` wins.

## Test plan
- **Signed, WIDTH=4:** `mcand`=4'b1001 (-7), `mplier`=4'b0110 (6). Required: `product`=8'hD6 (-42), `done` exactly 5 clocks after the accepting edge.
- **Unsigned, WIDTH=4:** same bit patterns. Required: `product`=8'h36 (54). Then 15×15. Required: 8'hE1.
- **Signed corners, WIDTH=4:** -8 × -8 gives 8'h40; -8 × 7 gives 8'hC8; 0 × -1 gives 8'h00.
- **Back-to-back, WIDTH=8:** `start` held high. Issue signed 8'h80×8'h7F (required 16'hC080), then unsigned 8'hFF×8'hFF (required 16'hFE01). Required: second `done` exactly 10 clocks after the first; `start` pulses during `busy` have no effect.
- **Reset mid-run:** assert `rst` on the third RUN cycle. Required: next cycle `busy`=0, `product`=0, no `done`. A fresh start then completes normally.
- **Random:** exhaustive for WIDTH=4 in both modes, plus 10k random vectors at WIDTH=16, checked against a reference model.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// Operands are extended by one bit so unsigned mode uses the same signed datapath.
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int AW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [AW-1:0]      m_q, m_d;
    logic [WIDTH:0]     q_q, q_d;
    logic               c_q, c_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     mcand_x;
    logic [WIDTH:0]     mplier_x;
    logic [AW-1:0]      acc_step;

    always_comb begin
        mcand_x  = {signed_mode & mcand[WIDTH-1], mcand};
        mplier_x = {signed_mode & mplier[WIDTH-1], mplier};
    end

    always_comb begin
        unique case ({q_q[0], c_q})
            2'b10:   acc_step = acc_q - m_q;
            2'b01:   acc_step = acc_q + m_q;
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    m_d     = {{(AW-WIDTH-1){mcand_x[WIDTH]}}, mcand_x};
                    q_d     = mplier_x;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                q_d   = {q_q[WIDTH], q_q[WIDTH:1]};
                c_d   = q_q[0];
                m_d   = {m_q[AW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                // The step taken with cnt==WIDTH is the last of WIDTH+1.
                if (cnt_q == LAST) begin
                    state_d   = S_DONE;
                    product_d = acc_step[2*WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
